k12a_mem_arbiter: RTL and testbench
===================================

K12A_MEM_ARBITER -- requirements
Module: k12a_mem_arbiter

Interface
REQ-001 SHALL have parameter WR_STROBE_CYCLES, default 1, meaning the number of cycles mem_we_n is held low per write (legal 1..15).
REQ-002 SHALL have port clock  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports cpu_req / cpu_write  in  1/1  CPU transfer request and direction (1=write).
REQ-005 SHALL have ports cpu_addr / cpu_wdata  in  16/8  CPU address and write data.
REQ-006 SHALL have ports cpu_rdata / cpu_ack  out  8/1  CPU read data and completion pulse.
REQ-007 SHALL have ports dma_req, dma_write, dma_addr, dma_wdata, dma_rdata, dma_ack, with widths and meanings identical to the cpu_* ports, for the DMA/loader port.
REQ-008 SHALL have port mem_addr  out  16  memory address.
REQ-009 SHALL have port mem_wdata  out  8  memory write data.
REQ-010 SHALL have port mem_wdata_oe  out  1  data-bus drive enable.
REQ-011 SHALL have port mem_rdata  in  8  memory read data.
REQ-012 SHALL have ports mem_rom_ce_n, mem_ram_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low memory strobes.
REQ-013 SHALL have port rom_write_err  out  1  one-cycle pulse flagging an attempted write to ROM.

Function
REQ-014 SHALL implement states IDLE, READ, WR_SETUP, WR_STROBE, WR_HOLD, ACK; all outputs registered or decoded from registered state only.
REQ-015 In IDLE with any request: SHALL latch owner, write, addr and wdata from the granted port, then go to READ (write=0) or WR_SETUP (write=1).
REQ-016 Arbitration: a single requester wins; if both request, the port not granted last wins (round-robin); last_grant updates on each grant.
REQ-017 READ (1 cycle): chip enable per addr[15] (0=ROM, 1=RAM), mem_oe_n=0; at the cycle's end SHALL capture mem_rdata into the owner's rdata register; next state ACK.
REQ-018 WR_SETUP (1 cycle): addr, wdata and mem_wdata_oe=1 driven; chip enable asserted; mem_we_n=1 and mem_oe_n=1.
REQ-019 WR_STROBE: mem_we_n=0 for exactly WR_STROBE_CYCLES cycles, counted by a 4-bit down-counter.
REQ-020 WR_HOLD (1 cycle): mem_we_n=1; addr, data and chip enable held; next state ACK.
REQ-021 Write to addr[15]=0: both chip enables and mem_we_n SHALL stay high throughout the write; rom_write_err SHALL pulse in ACK; ack is still issued.
REQ-022 ACK (1 cycle): owner's *_ack=1, no chip enable, requests ignored; next state IDLE.
REQ-023 Latency from req sampled in IDLE: read ack at cycle +2, write ack at cycle +3+WR_STROBE_CYCLES.
REQ-024 *_rdata SHALL hold its value until that port's next read completes; writes do not alter it.
REQ-025 Requester SHALL hold req/addr/wdata until ack; deasserting req mid-transfer SHALL NOT abort (latched values used); req still high in the cycle after ACK starts a new transfer.
REQ-026 mem_addr SHALL show the latched address in all non-IDLE/ACK states, and 0x0000 otherwise; mem_wdata_oe SHALL be 0 outside write states.
REQ-027 In IDLE/ACK: mem_oe_n=1, mem_we_n=1, both chip enables=1.

Reset
REQ-028 reset high at a rising edge SHALL force IDLE from any state (including mid-write), with strobes inactive from the next cycle.
REQ-029 Reset values: all *_ce_n/oe_n/we_n=1, mem_wdata_oe=0, mem_addr=0, acks=0, rom_write_err=0, cpu_rdata=dma_rdata=0x00, strobe counter=0, last_grant=DMA (CPU wins first tie).

Verification
REQ-030 CPU read 0x8010 with memory returning 0xA5 -> READ with ram_ce_n=0, oe_n=0; cpu_ack two cycles after req; cpu_rdata=0xA5.
REQ-031 DMA write 0x3C to 0x9000 with WR_STROBE_CYCLES=3 -> SETUP, 3 cycles we_n=0, HOLD; dma_ack at cycle +6; mem_wdata_oe=1 during SETUP..HOLD.
REQ-032 Both ports requesting reads continuously from reset -> grants CPU, DMA, CPU, DMA; no port is granted twice in a row.
REQ-033 CPU write to 0x0100 -> no chip enable and we_n stays 1; rom_write_err and cpu_ack pulse together in ACK.
REQ-034 reset asserted during WR_STROBE -> we_n=1 next cycle, state IDLE, no ack; a fresh request afterwards completes normally.
REQ-035 dma_req dropped in the cycle after grant -> transfer completes at the latched address and dma_ack still pulses.

Source files
------------

// File: rtl/k12a_mem_arbiter.sv
// Two-port (CPU / DMA) arbiter for an async ROM/RAM bus with round-robin tie-break.
// Writes use a setup / strobe / hold sequence on mem_we_n.
module k12a_mem_arbiter #(
  parameter int unsigned WR_STROBE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rom_ce_n,
  output logic        mem_ram_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        rom_write_err
);

  typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_STROBE, WR_HOLD, ACK} state_t;
  typedef enum logic {PORT_CPU, PORT_DMA} port_t;

  localparam logic [3:0] STROBE_LOAD = 4'(WR_STROBE_CYCLES);

  state_t      state, state_nx;
  port_t       owner, last_grant, grant;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [3:0]  strobe_cnt;
  logic        req_any;
  logic        grant_write;
  logic        active;
  logic        to_ram;

  // On a tie the port that did not win last time gets the bus.
  assign req_any     = cpu_req | dma_req;
  assign grant       = (dma_req && (!cpu_req || last_grant == PORT_CPU)) ? PORT_DMA : PORT_CPU;
  assign grant_write = (grant == PORT_DMA) ? dma_write : cpu_write;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (req_any) state_nx = grant_write ? WR_SETUP : READ;
      READ:      state_nx = ACK;
      WR_SETUP:  state_nx = WR_STROBE;
      WR_STROBE: if (strobe_cnt <= 4'd1) state_nx = WR_HOLD;
      WR_HOLD:   state_nx = ACK;
      ACK:       state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= PORT_CPU;
      last_grant <= PORT_DMA;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      strobe_cnt <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req_any) begin
          owner      <= grant;
          last_grant <= grant;
          wr         <= grant_write;
          addr       <= (grant == PORT_DMA) ? dma_addr  : cpu_addr;
          wdata      <= (grant == PORT_DMA) ? dma_wdata : cpu_wdata;
        end
        READ: begin
          if (owner == PORT_DMA) dma_rdata <= mem_rdata;
          else                   cpu_rdata <= mem_rdata;
        end
        WR_SETUP:  strobe_cnt <= STROBE_LOAD;
        WR_STROBE: strobe_cnt <= strobe_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // ROM writes walk the full write sequence but never assert a chip enable or we_n.
  always_comb begin
    active        = (state != IDLE) && (state != ACK);
    to_ram        = addr[15];
    mem_addr      = active ? addr : '0;
    mem_wdata_oe  = (state == WR_SETUP) || (state == WR_STROBE) || (state == WR_HOLD);
    mem_wdata     = mem_wdata_oe ? wdata : '0;
    mem_ram_ce_n  = !(active && to_ram);
    mem_rom_ce_n  = !(active && !to_ram && !wr);
    mem_oe_n      = !(state == READ);
    mem_we_n      = !(state == WR_STROBE && to_ram);
    cpu_ack       = (state == ACK) && (owner == PORT_CPU);
    dma_ack       = (state == ACK) && (owner == PORT_DMA);
    rom_write_err = (state == ACK) && wr && !to_ram;
  end

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// Bench for k12a_mem_arbiter: transfer table plus round-robin and reset-abort sequences,
// with acks checked against an expectation queue.
module tb_k12a_mem_arbiter;

  localparam int unsigned N_STB = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        dma_req = 1'b0, dma_write = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wdata_oe;
  logic [7:0]  mem_rdata;
  logic        mem_rom_ce_n, mem_ram_ce_n, mem_oe_n, mem_we_n;
  logic        rom_write_err;

  k12a_mem_arbiter #(.WR_STROBE_CYCLES(N_STB)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata(mem_rdata), .mem_rom_ce_n(mem_rom_ce_n), .mem_ram_ce_n(mem_ram_ce_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .rom_write_err(rom_write_err)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h35;
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  typedef struct {
    bit port; bit wr; logic [15:0] addr; logic [7:0] wdata; bit drop;
    int lat; int we_lo; int ram_lo; int rom_lo; int oe_lo; int drv;
  } vec_t;
  typedef struct { bit port; logic [7:0] rdata; bit err; } exp_t;

  exp_t        sb[$];
  logic [7:0]  last_rd[2];
  int          tests = 0, fails = 0;
  int          n_we, n_ram, n_rom, n_oe, n_drv, n_bus, n_ack;
  bit          ack_now, bus_chk;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  task automatic drive_port(input bit port, input logic req, input logic wr,
                            input logic [15:0] a, input logic [7:0] d);
    if (port) begin dma_req = req; dma_write = wr; dma_addr = a; dma_wdata = d; end
    else      begin cpu_req = req; cpu_write = wr; cpu_addr = a; cpu_wdata = d; end
  endtask

  // Called once per falling edge: accumulates strobe activity and pops the queue on ack.
  task automatic observe();
    exp_t e;
    ack_now = 1'b0;
    if (!mem_we_n)     n_we++;
    if (!mem_ram_ce_n) n_ram++;
    if (!mem_rom_ce_n) n_rom++;
    if (!mem_oe_n)     n_oe++;
    if (mem_wdata_oe)  n_drv++;
    if (bus_chk && (!mem_ram_ce_n || !mem_rom_ce_n || !mem_oe_n || !mem_we_n || mem_wdata_oe)) begin
      if (mem_addr !== cur_addr) n_bus++;
      if (mem_wdata_oe && mem_wdata !== cur_wdata) n_bus++;
    end
    if (cpu_ack && dma_ack) flag("dual_ack");
    if (cpu_ack || dma_ack) begin
      ack_now = 1'b1;
      n_ack++;
      chk("ack_bus_idle", {mem_addr, mem_ram_ce_n, mem_rom_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe},
          {16'h0000, 5'b11110});
      if (sb.size() == 0) flag("unexpected_ack");
      else begin
        e = sb.pop_front();
        chk("ack_port", {31'd0, dma_ack}, {31'd0, e.port});
        chk("rdata", dma_ack ? dma_rdata : cpu_rdata, e.rdata);
        chk("rom_write_err", {31'd0, rom_write_err}, {31'd0, e.err});
      end
    end else if (rom_write_err) flag("rom_write_err_without_ack");
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    drive_port(v.port, 1'b1, v.wr, v.addr, v.wdata);
    e.port = v.port;
    e.err  = v.wr && !v.addr[15];
    if (!v.wr) last_rd[v.port] = mem_f(v.addr);
    e.rdata = last_rd[v.port];
    sb.push_back(e);
    n_we = 0; n_ram = 0; n_rom = 0; n_oe = 0; n_drv = 0; n_bus = 0;
    cur_addr = v.addr; cur_wdata = v.wdata; bus_chk = 1'b1; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      observe();
      if (c == 1 && v.drop) drive_port(v.port, 1'b0, v.wr, ~v.addr, ~v.wdata);
      if (ack_now) begin lat = c; break; end
    end
    drive_port(v.port, 1'b0, 1'b0, 16'h0000, 8'h00);
    if (lat == 0) begin flag("ack_timeout"); sb.delete(); end
    chk("latency",     lat,    v.lat);
    chk("we_low",      n_we,   v.we_lo);
    chk("ram_ce_low",  n_ram,  v.ram_lo);
    chk("rom_ce_low",  n_rom,  v.rom_lo);
    chk("oe_low",      n_oe,   v.oe_lo);
    chk("wdata_drive", n_drv,  v.drv);
    chk("bus_values",  n_bus,  0);
    @(negedge clock);
    observe();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit   found;
    //          port wr  addr      wdata  drop lat we ram rom oe drv
    tbl[0] = '{1'b0, 1'b0, 16'h8010, 8'h00, 1'b0, 2, 0, 1, 0, 1, 0};
    tbl[1] = '{1'b1, 1'b1, 16'h9000, 8'h3C, 1'b0, 6, 3, 5, 0, 0, 5};
    tbl[2] = '{1'b0, 1'b1, 16'h0100, 8'h77, 1'b0, 6, 0, 0, 0, 0, 5};
    tbl[3] = '{1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 2, 0, 0, 1, 1, 0};
    tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 2, 0, 1, 0, 1, 0};
    tbl[5] = '{1'b1, 1'b1, 16'hA0A0, 8'h5E, 1'b1, 6, 3, 5, 0, 0, 5};
    tbl[6] = '{1'b1, 1'b0, 16'h7FFF, 8'h00, 1'b1, 2, 0, 0, 1, 1, 0};
    tbl[7] = '{1'b0, 1'b1, 16'h8000, 8'hFF, 1'b0, 6, 3, 5, 0, 0, 5};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 2, 0, 0, 1, 1, 0};
    tbl[9] = '{1'b1, 1'b0, 16'h8010, 8'h00, 1'b0, 2, 0, 1, 0, 1, 0};
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    bus_chk = 1'b0;

    repeat (2) @(negedge clock);
    chk("reset_strobes", {mem_rom_ce_n, mem_ram_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe,
                          cpu_ack, dma_ack, rom_write_err}, 8'b1111_0000);
    chk("reset_addr", mem_addr, 16'h0000);
    chk("reset_rdata", {cpu_rdata, dma_rdata}, 16'h0000);

    // Both ports read continuously out of reset: CPU must win first, then alternate.
    drive_port(1'b0, 1'b1, 1'b0, 16'h8001, 8'h00);
    drive_port(1'b1, 1'b1, 1'b0, 16'h0002, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.port  = i[0];
      e.rdata = e.port ? mem_f(16'h0002) : mem_f(16'h8001);
      e.err   = 1'b0;
      last_rd[e.port] = e.rdata;
      sb.push_back(e);
    end
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clock);
      observe();
    end
    drive_port(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive_port(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("rr_ack_count", n_ack, 4);
    sb.delete();
    @(negedge clock);
    observe();

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset in the middle of a write strobe aborts the transfer without an ack.
    bus_chk = 1'b0;
    drive_port(1'b1, 1'b1, 1'b1, 16'h9100, 8'h42);
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (!mem_we_n) begin found = 1'b1; break; end
    end
    chk("abort_strobe_seen", {31'd0, found}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_strobes", {mem_rom_ce_n, mem_ram_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe}, 5'b11110);
    chk("abort_ack", {cpu_ack, dma_ack}, 2'b00);
    chk("abort_addr", mem_addr, 16'h0000);
    chk("abort_rdata", {cpu_rdata, dma_rdata}, 16'h0000);
    reset = 1'b0;
    drive_port(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    n_ack = 0;
    repeat (4) begin
      @(negedge clock);
      observe();
    end
    chk("abort_no_ack", n_ack, 0);

    run_vec(tbl[9]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
